prv_trap_ctrl: RTL and testbench

//  Trap sequencer inside the priv block; consumes the exception/xret/wfi flags the hazard unit drives toward priv.

---
 rtl/prv_trap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_prv_trap_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/prv_trap_ctrl.sv
// Trap sequencer: prioritises exceptions/interrupts/xret/wfi, drains the pipe,
// then issues a one-cycle redirect together with the matching CSR update strobe.
module prv_trap_ctrl #(
  parameter int WORD_W          = 32,
  parameter int INT_SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [11:0]       exc_flags,
  input  logic [1:0]        curr_priv,
  input  logic [WORD_W-1:0] epc,
  input  logic [WORD_W-1:0] badaddr,
  input  logic              mret,
  input  logic              sret,
  input  logic              wfi,
  input  logic              pipe_clear,
  input  logic              timer_int,
  input  logic              soft_int,
  input  logic              ext_int,
  input  logic              mie_global,
  input  logic [2:0]        mie_mask,
  input  logic [WORD_W-1:0] mtvec,
  input  logic [WORD_W-1:0] mepc_r,
  input  logic [WORD_W-1:0] sepc_r,
  output logic              intr,
  output logic              insert_pc,
  output logic [WORD_W-1:0] priv_pc,
  output logic              trap_we,
  output logic [WORD_W-1:0] trap_cause,
  output logic [WORD_W-1:0] trap_epc,
  output logic [WORD_W-1:0] trap_val,
  output logic              xret_we,
  output logic              xret_is_s,
  output logic              wfi_stall
);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT, WFI_WAIT} state_t;

  state_t                     state_q, state_d;
  logic [INT_SYNC_STAGES-1:0] ext_sync_q;
  logic [WORD_W-1:0]          cause_q, cause_d;
  logic [WORD_W-1:0]          epc_q, epc_d;
  logic [WORD_W-1:0]          tval_q, tval_d;
  logic [WORD_W-1:0]          target_q, target_d;
  logic                       is_xret_q, is_xret_d;
  logic                       is_s_q, is_s_d;
  logic [2:0]                 pend;
  logic [4:0]                 exc_code, int_code;

  // Bit order of exc_flags: {st_pg,ld_pg,insn_pg,env,bkpt,mal_s,fault_s,mal_l,fault_l,illegal,mal_insn,fault_insn}
  function automatic logic [4:0] exc_cause(input logic [11:0] f, input logic [1:0] p);
    if      (f[7])  return 5'd3;
    else if (f[9])  return 5'd12;
    else if (f[0])  return 5'd1;
    else if (f[2])  return 5'd2;
    else if (f[1])  return 5'd0;
    else if (f[8])  return 5'd8 + {3'b000, p};
    else if (f[4])  return 5'd4;
    else if (f[6])  return 5'd6;
    else if (f[10]) return 5'd13;
    else if (f[11]) return 5'd15;
    else if (f[3])  return 5'd5;
    else            return 5'd7;
  endfunction

  function automatic logic [4:0] int_cause(input logic [2:0] pd);
    if      (pd[2]) return 5'd11;
    else if (pd[0]) return 5'd3;
    else            return 5'd7;
  endfunction

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  function automatic logic [WORD_W-1:0] trap_target(input logic [WORD_W-1:0] tvec,
                                                    input logic is_int,
                                                    input logic [4:0] code);
    logic [WORD_W-1:0] base;
    base = {tvec[WORD_W-1:2], 2'b00};
    if (tvec[1:0] == 2'b01 && is_int) return base + WORD_W'({code, 2'b00});
    else                              return base;
  endfunction

  assign pend = {ext_sync_q[INT_SYNC_STAGES-1], timer_int, soft_int} & mie_mask;

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    target_d  = target_q;
    is_xret_d = is_xret_q;
    is_s_d    = is_s_q;
    exc_code  = exc_cause(exc_flags, curr_priv);
    int_code  = int_cause(pend);
    case (state_q)
      IDLE: begin
        if (|exc_flags) begin
          cause_d   = WORD_W'(exc_code);
          epc_d     = epc;
          tval_d    = badaddr;
          target_d  = trap_target(mtvec, 1'b0, exc_code);
          is_xret_d = 1'b0;
          state_d   = DRAIN;
        end else if (mie_global && (|pend)) begin
          cause_d   = {1'b1, (WORD_W-1)'(int_code)};
          epc_d     = epc;
          tval_d    = '0;
          target_d  = trap_target(mtvec, 1'b1, int_code);
          is_xret_d = 1'b0;
          state_d   = DRAIN;
        end else if (mret || sret) begin
          target_d  = sret ? sepc_r : mepc_r;
          is_xret_d = 1'b1;
          is_s_d    = sret;
          state_d   = DRAIN;
        end else if (wfi && (pend == 3'b000)) begin
          state_d   = WFI_WAIT;
        end
      end
      DRAIN:    if (pipe_clear) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      WFI_WAIT: begin
        // Wake on any enabled pending line; the global enable only decides trap vs resume.
        if (|pend) begin
          if (mie_global) begin
            cause_d   = {1'b1, (WORD_W-1)'(int_code)};
            epc_d     = epc + WORD_W'(4);
            tval_d    = '0;
            target_d  = trap_target(mtvec, 1'b1, int_code);
            is_xret_d = 1'b0;
            state_d   = DRAIN;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ext_sync_q <= '0;
      cause_q    <= '0;
      epc_q      <= '0;
      tval_q     <= '0;
      target_q   <= '0;
      is_xret_q  <= 1'b0;
      is_s_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_sync_q <= (ext_sync_q << 1) | INT_SYNC_STAGES'(ext_int);
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      tval_q     <= tval_d;
      target_q   <= target_d;
      is_xret_q  <= is_xret_d;
      is_s_q     <= is_s_d;
    end
  end

  assign intr       = (state_q == DRAIN) || (state_q == REDIRECT);
  assign insert_pc  = (state_q == REDIRECT);
  assign priv_pc    = insert_pc ? target_q : '0;
  assign trap_we    = insert_pc && !is_xret_q;
  assign xret_we    = insert_pc && is_xret_q;
  assign xret_is_s  = xret_we && is_s_q;
  assign wfi_stall  = (state_q == WFI_WAIT);
  assign trap_cause = cause_q;
  assign trap_epc   = epc_q;
  assign trap_val   = tval_q;

endmodule

// File: tb/tb_prv_trap_ctrl.sv
// Directed bench for prv_trap_ctrl: exceptions, interrupts, xret, wfi, reset abort.
module tb_prv_trap_ctrl;
  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [11:0]   exc_flags;
  logic [1:0]    curr_priv;
  logic [W-1:0]  epc, badaddr, mtvec, mepc_r, sepc_r;
  logic          mret, sret, wfi, pipe_clear, timer_int, soft_int, ext_int, mie_global;
  logic [2:0]    mie_mask;
  logic          intr, insert_pc, trap_we, xret_we, xret_is_s, wfi_stall;
  logic [W-1:0]  priv_pc, trap_cause, trap_epc, trap_val;

  int checks = 0;
  int errors = 0;

  prv_trap_ctrl #(.WORD_W(W), .INT_SYNC_STAGES(2)) dut (
    .CLK(CLK), .nRST(nRST), .exc_flags(exc_flags), .curr_priv(curr_priv),
    .epc(epc), .badaddr(badaddr), .mret(mret), .sret(sret), .wfi(wfi),
    .pipe_clear(pipe_clear), .timer_int(timer_int), .soft_int(soft_int),
    .ext_int(ext_int), .mie_global(mie_global), .mie_mask(mie_mask),
    .mtvec(mtvec), .mepc_r(mepc_r), .sepc_r(sepc_r), .intr(intr),
    .insert_pc(insert_pc), .priv_pc(priv_pc), .trap_we(trap_we),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_val(trap_val),
    .xret_we(xret_we), .xret_is_s(xret_is_s), .wfi_stall(wfi_stall)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one exception with pipe_clear already high; returns in the REDIRECT cycle.
  task automatic run_exc(input logic [11:0] f, input logic [1:0] p);
    exc_flags = f; curr_priv = p; pipe_clear = 1'b1;
    tick();
    exc_flags = '0;
    tick();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    tick(); tick();
    checks++; if (intr !== 1'b0)       begin errors++; $display("FAIL rst_intr got %b exp 0", intr); end
    checks++; if (insert_pc !== 1'b0)  begin errors++; $display("FAIL rst_insert_pc got %b exp 0", insert_pc); end
    checks++; if (trap_we !== 1'b0 || xret_we !== 1'b0 || xret_is_s !== 1'b0 || wfi_stall !== 1'b0)
      begin errors++; $display("FAIL rst_strobes got %b%b%b%b exp 0000", trap_we, xret_we, xret_is_s, wfi_stall); end
    checks++; if (priv_pc !== '0 || trap_cause !== '0 || trap_epc !== '0 || trap_val !== '0)
      begin errors++; $display("FAIL rst_data got %h %h %h %h exp 0", priv_pc, trap_cause, trap_epc, trap_val); end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    mtvec = 32'h100; epc = 32'h200; badaddr = 32'hDEADBEEF;
    exc_flags = 12'h004;
    tick();
    exc_flags = '0; pipe_clear = 1'b1;
    checks++; if (intr !== 1'b1 || insert_pc !== 1'b0)
      begin errors++; $display("FAIL ill_drain got intr=%b ins=%b exp 1 0", intr, insert_pc); end
    tick();
    checks++; if (insert_pc !== 1'b1 || trap_we !== 1'b1 || xret_we !== 1'b0)
      begin errors++; $display("FAIL ill_strobe got ins=%b we=%b xw=%b exp 1 1 0", insert_pc, trap_we, xret_we); end
    checks++; if (priv_pc !== 32'h100) begin errors++; $display("FAIL ill_pc got %h exp 00000100", priv_pc); end
    checks++; if (trap_cause !== 32'd2) begin errors++; $display("FAIL ill_cause got %h exp 2", trap_cause); end
    checks++; if (trap_val !== 32'hDEADBEEF) begin errors++; $display("FAIL ill_tval got %h exp deadbeef", trap_val); end
    checks++; if (trap_epc !== 32'h200) begin errors++; $display("FAIL ill_epc got %h exp 200", trap_epc); end
    tick();
    checks++; if (insert_pc !== 1'b0 || intr !== 1'b0)
      begin errors++; $display("FAIL ill_done got ins=%b intr=%b exp 0 0", insert_pc, intr); end
    pipe_clear = 1'b0;
  endtask

  task automatic test_exc_priority();
    mtvec = 32'h101;
    run_exc(12'h210, 2'd0);  // insn page + mal_l
    checks++; if (trap_cause !== 32'd12) begin errors++; $display("FAIL pri_page_cause got %h exp c", trap_cause); end
    checks++; if (priv_pc !== 32'h100) begin errors++; $display("FAIL pri_exc_novec got %h exp 100", priv_pc); end
    tick();
    run_exc(12'h100, 2'd0);  // env from U
    checks++; if (trap_cause !== 32'd8) begin errors++; $display("FAIL env_u_cause got %h exp 8", trap_cause); end
    tick();
    run_exc(12'h100, 2'd3);  // env from M
    checks++; if (trap_cause !== 32'd11) begin errors++; $display("FAIL env_m_cause got %h exp b", trap_cause); end
    tick();
    run_exc(12'hC28, 2'd0);  // st_pg, ld_pg, fault_s, fault_l
    checks++; if (trap_cause !== 32'd13) begin errors++; $display("FAIL ldpg_cause got %h exp d", trap_cause); end
    tick();
    run_exc(12'h028, 2'd0);  // fault_s + fault_l
    checks++; if (trap_cause !== 32'd5) begin errors++; $display("FAIL fault_ls_cause got %h exp 5", trap_cause); end
    tick();
    run_exc(12'h007, 2'd0);  // illegal, mal_insn, fault_insn
    checks++; if (trap_cause !== 32'd1) begin errors++; $display("FAIL finsn_cause got %h exp 1", trap_cause); end
    tick();
    pipe_clear = 1'b0;
  endtask

  task automatic test_ext_int();
    mtvec = 32'h101; mie_mask = 3'b100; mie_global = 1'b1; pipe_clear = 1'b1;
    ext_int = 1'b1;
    tick();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL ext_sync1 got intr=%b exp 0", intr); end
    tick();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL ext_sync2 got intr=%b exp 0", intr); end
    tick();
    checks++; if (intr !== 1'b1 || insert_pc !== 1'b0)
      begin errors++; $display("FAIL ext_drain got intr=%b ins=%b exp 1 0", intr, insert_pc); end
    tick();
    checks++; if (insert_pc !== 1'b1 || trap_we !== 1'b1)
      begin errors++; $display("FAIL ext_strobe got ins=%b we=%b exp 1 1", insert_pc, trap_we); end
    checks++; if (trap_cause !== 32'h8000000B) begin errors++; $display("FAIL ext_cause got %h exp 8000000b", trap_cause); end
    checks++; if (priv_pc !== 32'h12C) begin errors++; $display("FAIL ext_pc got %h exp 12c", priv_pc); end
    checks++; if (trap_val !== 32'h0) begin errors++; $display("FAIL ext_tval got %h exp 0", trap_val); end
    ext_int = 1'b0; mie_global = 1'b0; pipe_clear = 1'b0;
    tick(); tick(); tick();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL ext_masked got intr=%b exp 0", intr); end
    mie_mask = 3'b000;
  endtask

  task automatic test_xret();
    mepc_r = 32'h80; sepc_r = 32'h440; pipe_clear = 1'b0;
    mret = 1'b1;
    tick();
    mret = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (intr !== 1'b1 || insert_pc !== 1'b0)
        begin errors++; $display("FAIL mret_hold%0d got intr=%b ins=%b exp 1 0", i, intr, insert_pc); end
      if (i < 4) tick();
    end
    pipe_clear = 1'b1;
    tick();
    checks++; if (insert_pc !== 1'b1 || xret_we !== 1'b1 || trap_we !== 1'b0 || xret_is_s !== 1'b0)
      begin errors++; $display("FAIL mret_strobe got ins=%b xw=%b tw=%b s=%b exp 1 1 0 0", insert_pc, xret_we, trap_we, xret_is_s); end
    checks++; if (priv_pc !== 32'h80) begin errors++; $display("FAIL mret_pc got %h exp 80", priv_pc); end
    tick();
    checks++; if (insert_pc !== 1'b0 || intr !== 1'b0)
      begin errors++; $display("FAIL mret_single got ins=%b intr=%b exp 0 0", insert_pc, intr); end
    sret = 1'b1;
    tick();
    sret = 1'b0;
    tick();
    checks++; if (xret_we !== 1'b1 || xret_is_s !== 1'b1 || priv_pc !== 32'h440)
      begin errors++; $display("FAIL sret got xw=%b s=%b pc=%h exp 1 1 440", xret_we, xret_is_s, priv_pc); end
    tick();
    pipe_clear = 1'b0;
  endtask

  task automatic test_wfi();
    mtvec = 32'h100; mie_mask = 3'b010; mie_global = 1'b0; timer_int = 1'b0;
    wfi = 1'b1;
    tick();
    wfi = 1'b0;
    checks++; if (wfi_stall !== 1'b1) begin errors++; $display("FAIL wfi_park got %b exp 1", wfi_stall); end
    tick();
    checks++; if (wfi_stall !== 1'b1 || intr !== 1'b0)
      begin errors++; $display("FAIL wfi_hold got stall=%b intr=%b exp 1 0", wfi_stall, intr); end
    timer_int = 1'b1;
    tick();
    checks++; if (wfi_stall !== 1'b0 || intr !== 1'b0)
      begin errors++; $display("FAIL wfi_resume got stall=%b intr=%b exp 0 0", wfi_stall, intr); end
    timer_int = 1'b0;
    tick();
    checks++; if (insert_pc !== 1'b0) begin errors++; $display("FAIL wfi_noredir got %b exp 0", insert_pc); end
    mie_global = 1'b1; epc = 32'h400; pipe_clear = 1'b1;
    wfi = 1'b1;
    tick();
    wfi = 1'b0; timer_int = 1'b1;
    tick();
    checks++; if (intr !== 1'b1 || wfi_stall !== 1'b0 || trap_epc !== 32'h404)
      begin errors++; $display("FAIL wfi_wake got intr=%b stall=%b epc=%h exp 1 0 404", intr, wfi_stall, trap_epc); end
    tick();
    checks++; if (insert_pc !== 1'b1 || trap_cause !== 32'h80000007 || priv_pc !== 32'h100)
      begin errors++; $display("FAIL wfi_trap got ins=%b cause=%h pc=%h exp 1 80000007 100", insert_pc, trap_cause, priv_pc); end
    timer_int = 1'b0; mie_global = 1'b0; pipe_clear = 1'b0; mie_mask = 3'b000;
    tick();
  endtask

  task automatic test_reset_in_drain();
    pipe_clear = 1'b0;
    exc_flags = 12'h004;
    tick();
    exc_flags = '0;
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL rd_drain got intr=%b exp 1", intr); end
    nRST = 1'b0;
    #1;
    checks++; if (intr !== 1'b0 || trap_cause !== '0 || trap_val !== '0 || trap_epc !== '0)
      begin errors++; $display("FAIL rd_async got intr=%b cause=%h tval=%h epc=%h exp 0", intr, trap_cause, trap_val, trap_epc); end
    #2;
    nRST = 1'b1;
    pipe_clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (insert_pc !== 1'b0 || intr !== 1'b0)
        begin errors++; $display("FAIL rd_noredir%0d got ins=%b intr=%b exp 0 0", i, insert_pc, intr); end
    end
    pipe_clear = 1'b0;
  endtask

  task automatic test_back_to_back();
    mtvec = 32'h101; mie_mask = 3'b001; mie_global = 1'b1; pipe_clear = 1'b1;
    exc_flags = 12'h080; soft_int = 1'b1;
    tick();
    exc_flags = '0;
    tick();
    checks++; if (insert_pc !== 1'b1 || trap_cause !== 32'd3 || priv_pc !== 32'h100)
      begin errors++; $display("FAIL b2b_bkpt got ins=%b cause=%h pc=%h exp 1 3 100", insert_pc, trap_cause, priv_pc); end
    tick();
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL b2b_idle got intr=%b exp 0", intr); end
    tick();
    checks++; if (intr !== 1'b1 || insert_pc !== 1'b0)
      begin errors++; $display("FAIL b2b_drain got intr=%b ins=%b exp 1 0", intr, insert_pc); end
    tick();
    checks++; if (insert_pc !== 1'b1 || trap_cause !== 32'h80000003 || priv_pc !== 32'h10C)
      begin errors++; $display("FAIL b2b_soft got ins=%b cause=%h pc=%h exp 1 80000003 10c", insert_pc, trap_cause, priv_pc); end
    soft_int = 1'b0; mie_global = 1'b0; pipe_clear = 1'b0;
    tick();
  endtask

  initial begin
    nRST = 1'b0; exc_flags = '0; curr_priv = 2'd3; epc = '0; badaddr = '0;
    mret = 1'b0; sret = 1'b0; wfi = 1'b0; pipe_clear = 1'b0;
    timer_int = 1'b0; soft_int = 1'b0; ext_int = 1'b0; mie_global = 1'b0;
    mie_mask = 3'b000; mtvec = '0; mepc_r = '0; sepc_r = '0;
    test_reset();
    test_illegal();
    test_exc_priority();
    test_ext_int();
    test_xret();
    test_wfi();
    test_reset_in_drain();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
